// File: rtl/regfile_dump_controller.sv
// regfile_dump_controller
// Walks the register file from entry 0 to NUM_REGS-1 through the shared read
// port and streams each (index, value) pair out over a valid/ready interface.
// The core always wins the read port. A dump only advances on cycles where the
// core leaves the port free.
module regfile_dump_controller #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int AW       = 5    // must satisfy 2**AW >= NUM_REGS
) (
    input  logic            clk_i,
    input  logic            reset_i,        // asynchronous, active low
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            core_rd_req_i,
    output logic            rf_rd_sel_o,
    output logic [AW-1:0]   rf_rd_addr_o,
    input  logic [XLEN-1:0] rf_rd_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [AW-1:0]   out_index_o,
    output logic [XLEN-1:0] out_data_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DONE} state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    state_e          state_q;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   out_index_q;
    logic [XLEN-1:0] out_data_q;
    logic            out_valid_q;
    logic            busy_q;
    logic            done_q;

    // The dump owns the read port only while requesting and the core is idle.
    assign rf_rd_sel_o  = (state_q == REQ) && !core_rd_req_i;
    assign rf_rd_addr_o = idx_q;

    assign out_valid_o = out_valid_q;
    assign out_index_o = out_index_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    // Dump sequencer: state, walk index and registered status/beat outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= REQ;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                REQ: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (!core_rd_req_i) begin
                        // Read port is ours this cycle: latch the beat.
                        out_data_q  <= rf_rd_data_i;
                        out_index_q <= idx_q;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    // abort beats a simultaneous handshake, including the last beat.
                    if (abort_i) begin
                        state_q     <= IDLE;
                        idx_q       <= '0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + AW'(1);
                            state_q <= REQ;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
                default: begin
                    state_q     <= IDLE;
                    idx_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_controller.sv
// tb_regfile_dump_controller
// Directed and randomized dump runs against a beat-level reference model:
// register file contents in an array, and a two-phase (requesting / holding)
// view of each beat derived from the contention and handshake rules.
module tb_regfile_dump_controller;

    localparam int N    = 32;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            core = 1'b0;
    logic            ready = 1'b0;
    logic            rf_rd_sel;
    logic [AW-1:0]   rf_rd_addr;
    logic [XLEN-1:0] rf_rd_data;
    logic            out_valid;
    logic [AW-1:0]   out_index;
    logic [XLEN-1:0] out_data;
    logic            busy;
    logic            done;

    logic [XLEN-1:0] rf [N];

    int nvec = 0;
    int nerr = 0;

    assign rf_rd_data = rf[rf_rd_addr];

    always #5 clk = ~clk;

    regfile_dump_controller #(.NUM_REGS(N), .XLEN(XLEN), .AW(AW)) dut (
        .clk_i         (clk),
        .reset_i       (rst_n),
        .start_i       (start),
        .abort_i       (abort),
        .core_rd_req_i (core),
        .rf_rd_sel_o   (rf_rd_sel),
        .rf_rd_addr_o  (rf_rd_addr),
        .rf_rd_data_i  (rf_rd_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (ready),
        .out_index_o   (out_index),
        .out_data_o    (out_data),
        .busy_o        (busy),
        .done_o        (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) rf[i] = $urandom;
    endtask

    // One full dump from start to done. Backpressure of bp_len cycles on beat
    // bp_beat, core contention of ct_len cycles on beat ct_beat, plus random
    // ready/contention at the given percentages. exp_cyc > 0 checks the edge
    // count from the start-sampling edge to the edge that raises done.
    task automatic run_dump(input int rdy_pct, input int core_pct,
                            input int bp_beat, input int bp_len,
                            input int ct_beat, input int ct_len,
                            input int exp_cyc, input bit spam);
        int beats = 0;
        int cyc = 0;
        int bp = 0;
        int ct = 0;
        bit hold = 0;
        bit fin = 0;
        start = 1'b1;
        step();
        start = spam;
        while (!fin && cyc < 4000) begin
            if (hold && beats == bp_beat && bp < bp_len) begin
                ready = 1'b0; bp++;
            end else ready = ($urandom_range(99) < rdy_pct);
            if (!hold && beats == ct_beat && ct < ct_len) begin
                core = 1'b1; ct++;
            end else core = ($urandom_range(99) < core_pct);
            #1;
            check("rd_sel", rf_rd_sel, !hold && !core);
            check("valid", out_valid, hold);
            check("busy", busy, 1);
            check("done_early", done, 0);
            if (hold) begin
                check("index", out_index, beats);
                check("data", out_data, rf[beats]);
            end
            if (hold && ready) begin
                beats++;
                hold = 0;
                if (beats == N) fin = 1;
            end else if (!hold && !core) begin
                hold = 1;
            end
            step();
            cyc++;
        end
        check("done", done, fin);
        check("busy_at_done", busy, 0);
        check("valid_at_done", out_valid, 0);
        if (exp_cyc > 0) check("latency", cyc, exp_cyc);
        ready = 1'b0;
        core  = 1'b0;
        step();
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        step();
        check("idle_busy2", busy, 0);
        check("idle_done2", done, 0);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel", rf_rd_sel, 0);
        check("rst_index", out_index, 0);
        check("rst_data", out_data, 0);
        #7 rst_n = 1'b1;
        step();

        // 1: clean dump of a patterned register file, 64 cycles to done
        for (int i = 0; i < N; i++) rf[i] = i * 32'h01010101;
        run_dump(100, 0, -1, 0, -1, 0, 64, 0);

        // 2: five cycles of backpressure on beat 7
        run_dump(100, 0, 7, 5, -1, 0, 69, 0);

        // 3: core holds the port for four cycles on beat 3
        run_dump(100, 0, -1, 0, 3, 4, 68, 0);

        // 4: abort while beat 10 is being handshaken
        ready = 1'b1;
        core  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid && out_index == 10) break;
            step();
        end
        check("abort_pre_valid", out_valid, 1);
        check("abort_pre_index", out_index, 10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", done, 0);
            check("abort_idle", busy, 0);
        end
        run_dump(100, 0, -1, 0, -1, 0, 64, 0);

        // 5: asynchronous reset in the middle of a held beat
        fill_random();
        ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("hold_before_reset", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_sel", rf_rd_sel, 0);
        check("arst_index", out_index, 0);
        #3 rst_n = 1'b1;
        step();
        check("post_rst_busy", busy, 0);
        run_dump(100, 0, -1, 0, -1, 0, 64, 0);

        // 6: start held high while busy and through the DONE cycle
        run_dump(100, 0, -1, 0, -1, 0, 64, 1);

        // Randomized ready and contention over random contents
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_dump(60, 30, -1, 0, -1, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/regfile_dump_controller.md
Name: regfile_dump_controller

Overview:
- Sequencer that walks the core register file, reading every entry from RegFile[0] to RegFile[NUM_REGS-1] through the shared read port.
- Streams each (index, value) pair out over a valid/ready interface, for debug dump and checkpoint.
- Shares the read port with the core; the core always has priority.
- Sits beside the core's register file inside risc_v_microcontroller.

Parameters:
NUM_REGS, 32, number of register-file entries to dump
XLEN, 32, register data width
AW, 5, index/address width; must satisfy 2**AW >= NUM_REGS

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request a dump; sampled only in IDLE
abort  in  1  cancel the dump in progress
core_rd_req  in  1  core is using the shared read port this cycle
rf_rd_sel  out  1  1 = read-port mux selects the dump address
rf_rd_addr  out  AW  dump read address
rf_rd_data  in  XLEN  register-file read data, combinational from rf_rd_addr
out_valid  out  1  dump beat valid
out_ready  in  1  downstream accepts the beat
out_index  out  AW  register index of the beat
out_data  out  XLEN  register value of the beat
busy  out  1  dump in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, idx=0.
  - rf_rd_sel, out_valid, busy and done are 0; out_index and out_data are 0.
  - Reset mid-dump discards all progress; no done pulse.
- States IDLE, REQ, HOLD, DONE.
- IDLE:
  - start=1 at an edge → REQ with idx=0.
  - start in any other state is ignored (no queuing).
- REQ:
  - rf_rd_sel = !core_rd_req (combinational).
  - rf_rd_addr = idx at all times.
  - If core_rd_req=0 at the edge: capture out_data<=rf_rd_data and out_index<=idx, then → HOLD.
  - If core_rd_req=1: stay in REQ. Core priority is absolute; a stall has no bound.
- HOLD:
  - out_valid=1.
  - out_index and out_data stay stable until the handshake.
  - On out_valid && out_ready at the edge: if idx==NUM_REGS-1 → DONE, else idx<=idx+1 → REQ.
- DONE:
  - done=1 for exactly one cycle, then → IDLE; idx returns to 0.
- Status outputs:
  - busy=1 in REQ and HOLD only; 0 in IDLE and DONE.
  - out_valid=0 outside HOLD.
- abort:
  - In REQ or HOLD, abort at an edge forces → IDLE: out_valid drops next cycle, no done.
  - abort overrides a simultaneous handshake or last-beat transition.
  - abort in IDLE or DONE has no effect; a DONE-cycle done pulse still completes.
- Latency:
  - With no contention and out_ready=1, each register takes 2 cycles.
  - start sampled at edge e0 → beat k valid between e(2k+1) and e(2k+2).
  - done is high between e(2·NUM_REGS) and e(2·NUM_REGS+1).
  - For 32 registers, done rises 64 cycles after start is sampled.
- Index arithmetic:
  - idx never exceeds NUM_REGS-1; no wrap-around.
  - Non-power-of-two NUM_REGS is supported.
  - Register 0 is dumped as whatever the register file returns (expected 0).
- No combinational path from out_ready to any output.
- rf_rd_sel depends combinationally only on state and core_rd_req.

Test Plan:
1. Preload RegFile[i]=i·0x01010101, hold reset low for 10 ns then release, pulse start, out_ready=1, core_rd_req=0 → 32 beats with out_index 0..31 and matching data, each beat valid for one cycle, done high exactly 64 cycles after start is sampled, busy low afterwards.
2. Backpressure: out_ready=0 for 5 cycles on beat 7 → out_index=7 and out_data held stable with out_valid=1 throughout; beat 8 follows the handshake and the final count is still 32 beats.
3. Contention: core_rd_req=1 for 4 cycles while in REQ for idx=3 → rf_rd_sel=0 during those cycles and no beat issued; beat 3 appears the cycle after core_rd_req drops with the correct data; total time to done is 68 cycles.
4. Abort at beat 10 with out_ready=1 in the same cycle → out_valid low next cycle, busy=0, no done pulse; a new start restarts from index 0.
5. Async reset asserted mid-HOLD (not on a clock edge) → out_valid, busy and rf_rd_sel go 0 immediately; after release, start gives a full 32-beat dump.
6. start pulsed again while busy and in the DONE cycle → ignored: exactly one dump and one done pulse.
